ls_queue: RTL and testbench

- In-order load/store queue sitting directly upstream of the load/store issue stage (data-cache wrapper).
- Accepts memory ops from dispatch, computes effective address, and snoops the CDB for pending store data.
- Presents the oldest ready op to the issue stage over a valid/accept handshake.
- Strict program order: only the head entry may issue.

---
 rtl/ls_queue.sv | 173 +++++++++++++++++
 tb/tb_ls_queue.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ls_queue : in-order load/store queue feeding the data-cache issue stage    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ls_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic             disp_opcode,
  input  logic [5:0]       disp_tag,
  input  logic [31:0]      disp_base,
  input  logic [15:0]      disp_offset,
  input  logic [31:0]      disp_data,
  input  logic             disp_data_valid,
  input  logic [5:0]       disp_data_tag,
  input  logic             cdb_valid,
  input  logic [5:0]       cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             lsq_full,
  output logic [PTR_W:0]   lsq_count,
  output logic             ls_ready_out,
  output logic [31:0]      ls_data,
  output logic [31:0]      ls_address,
  output logic [5:0]       ls_tag,
  output logic             opcode,
  input  logic             ls_accept
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_load;

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_data_ready;
  logic [DEPTH-1:0]  r_store;
  logic [5:0]        r_tag      [DEPTH];
  logic [31:0]       r_addr     [DEPTH];
  logic [31:0]       r_data     [DEPTH];
  logic [5:0]        r_data_tag [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_head_ready;
  logic              w_bypass;
  logic              w_disp_ready;
  logic [31:0]       w_disp_data;
  logic [31:0]       w_disp_addr;
  logic [DEPTH-1:0]  w_snoop_hit;

  assign lsq_full     = (r_count == c_depth);
  assign lsq_count    = r_count;
  assign ls_ready_out = (r_state == ST_REQ);

  assign w_push       = disp_valid && !lsq_full;
  assign w_pop        = (r_state == ST_REQ) && ls_accept;
  assign w_head_ready = r_valid[r_head] && r_data_ready[r_head];
  assign w_disp_addr  = disp_base + {{16{disp_offset[15]}}, disp_offset};

  // A store whose data producer broadcasts in its dispatch cycle takes the CDB value directly.
  assign w_bypass     = disp_opcode && !disp_data_valid && cdb_valid && (disp_data_tag == cdb_tag);
  assign w_disp_ready = !disp_opcode || disp_data_valid || w_bypass;
  assign w_disp_data  = w_bypass ? cdb_data : disp_data;

  always_comb begin
    w_snoop_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_snoop_hit[i] = r_valid[i] && r_store[i] && !r_data_ready[i] &&
                       cdb_valid && (r_data_tag[i] == cdb_tag);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= '0;
      r_data_ready <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else if (flush) begin
      r_valid      <= '0;
      r_data_ready <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_snoop_hit[i]) r_data_ready[i] <= 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_valid[r_tail]      <= 1'b1;
        r_data_ready[r_tail] <= w_disp_ready;
        r_tail               <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Payload needs no reset: every read is qualified by a valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_snoop_hit[i]) r_data[i] <= cdb_data;
    end
    if (w_push) begin
      r_store[r_tail]    <= disp_opcode;
      r_tag[r_tail]      <= disp_tag;
      r_addr[r_tail]     <= w_disp_addr;
      r_data[r_tail]     <= w_disp_data;
      r_data_tag[r_tail] <= disp_data_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_head_ready) begin
            w_state_nxt = ST_REQ;
            w_load      = 1'b1;
          end
        end
        ST_REQ: begin
          if (ls_accept) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Request fields are captured on entry to REQ and held until the accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_data    <= '0;
      ls_address <= '0;
      ls_tag     <= '0;
      opcode     <= 1'b0;
    end else if (w_load) begin
      ls_data    <= r_data[r_head];
      ls_address <= r_addr[r_head];
      ls_tag     <= r_tag[r_head];
      opcode     <= r_store[r_head];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ls_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ls_queue : scoreboard bench for the in-order load/store queue           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ls_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_opcode = 1'b0;
  logic [5:0]  disp_tag = '0;
  logic [31:0] disp_base = '0;
  logic [15:0] disp_offset = '0;
  logic [31:0] disp_data = '0;
  logic        disp_data_valid = 1'b0;
  logic [5:0]  disp_data_tag = '0;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        lsq_full;
  logic [3:0]  lsq_count;
  logic        ls_ready_out;
  logic [31:0] ls_data;
  logic [31:0] ls_address;
  logic [5:0]  ls_tag;
  logic        opcode;
  logic        ls_accept = 1'b0;

  ls_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_tag(disp_tag),
    .disp_base(disp_base), .disp_offset(disp_offset), .disp_data(disp_data),
    .disp_data_valid(disp_data_valid), .disp_data_tag(disp_data_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .lsq_full(lsq_full), .lsq_count(lsq_count), .ls_ready_out(ls_ready_out),
    .ls_data(ls_data), .ls_address(ls_address), .ls_tag(ls_tag),
    .opcode(opcode), .ls_accept(ls_accept)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic        op;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t got;
  bit   ok;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single cycle and records what it must issue as.
  task automatic drive_disp(input logic op, input logic [5:0] tag, input logic [31:0] base,
                            input logic [15:0] off, input logic [31:0] data, input logic dv,
                            input logic [5:0] dtag, input logic [31:0] exp_data);
    disp_valid = 1'b1; disp_opcode = op; disp_tag = tag; disp_base = base;
    disp_offset = off; disp_data = data; disp_data_valid = dv; disp_data_tag = dtag;
    sb.push_back('{tag: tag, addr: base + {{16{off[15]}}, off}, data: exp_data, op: op});
    step();
    disp_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, captures it, and accepts it.
  task automatic take_head(input int budget, output bit found, output exp_t seen);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (ls_ready_out) found = 1'b1;
      else step();
    end
    seen = '{tag: ls_tag, addr: ls_address, data: ls_data, op: opcode};
    if (found) begin
      ls_accept = 1'b1;
      step();
      ls_accept = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    n_checks++;
    if ({lsq_full, lsq_count, ls_ready_out, ls_data, ls_address, ls_tag, opcode} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got full=%0b cnt=%0d rdy=%0b data=%h addr=%h tag=%h op=%0b, want all zero",
               lsq_full, lsq_count, ls_ready_out, ls_data, ls_address, ls_tag, opcode);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_load();
    exp_t snap;
    drive_disp(1'b0, 6'h21, 32'h0000_1000, 16'hFFFC, 32'h0, 1'b1, 6'h0, 32'h0);
    n_checks++;
    if (ls_ready_out !== 1'b0 || lsq_count !== 4'd1) begin
      n_errors++;
      $display("FAIL load_first_cycle: got rdy=%0b cnt=%0d, want rdy=0 cnt=1", ls_ready_out, lsq_count);
    end
    step();
    n_checks++;
    if (ls_ready_out !== 1'b1 || ls_address !== 32'h0000_0FFC || ls_tag !== 6'h21 || opcode !== 1'b0) begin
      n_errors++;
      $display("FAIL load_latency: got rdy=%0b addr=%h tag=%h op=%0b, want rdy=1 addr=00000ffc tag=21 op=0",
               ls_ready_out, ls_address, ls_tag, opcode);
    end
    snap = '{tag: ls_tag, addr: ls_address, data: ls_data, op: opcode};
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (ls_ready_out !== 1'b1 || {ls_tag, ls_address, ls_data, opcode} !== snap) begin
        n_errors++;
        $display("FAIL load_hold: cycle %0d got rdy=%0b tag=%h addr=%h, want rdy=1 tag=%h addr=%h",
                 c, ls_ready_out, ls_tag, ls_address, snap.tag, snap.addr);
      end
    end
    take_head(1, ok, got);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got.op !== e.op || got.tag !== e.tag || got.addr !== e.addr) begin
      n_errors++;
      $display("FAIL load_issue: ok=%0b got op=%0b tag=%h addr=%h, want op=%0b tag=%h addr=%h",
               ok, got.op, got.tag, got.addr, e.op, e.tag, e.addr);
    end
    n_checks++;
    if (ls_ready_out !== 1'b0 || lsq_count !== 4'd0) begin
      n_errors++;
      $display("FAIL load_after_accept: got rdy=%0b cnt=%0d, want rdy=0 cnt=0", ls_ready_out, lsq_count);
    end
  endtask

  task automatic test_store_cdb();
    drive_disp(1'b1, 6'h05, 32'h0000_2000, 16'h0010, 32'hAAAA_AAAA, 1'b0, 6'h15, 32'hDEAD_BEEF);
    step();
    cdb_valid = 1'b1; cdb_tag = 6'h14; cdb_data = 32'h1111_1111;
    step();
    cdb_valid = 1'b0;
    n_checks++;
    if (ls_ready_out !== 1'b0) begin
      n_errors++;
      $display("FAIL store_wrong_tag_a: got rdy=%0b, want 0", ls_ready_out);
    end
    step();
    n_checks++;
    if (ls_ready_out !== 1'b0) begin
      n_errors++;
      $display("FAIL store_wrong_tag_b: got rdy=%0b, want 0", ls_ready_out);
    end
    cdb_valid = 1'b1; cdb_tag = 6'h15; cdb_data = 32'hDEAD_BEEF;
    step();
    cdb_valid = 1'b0;
    n_checks++;
    if (ls_ready_out !== 1'b0) begin
      n_errors++;
      $display("FAIL store_cdb_early: got rdy=%0b, want 0", ls_ready_out);
    end
    step();
    take_head(1, ok, got);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got.op !== e.op || got.tag !== e.tag || got.addr !== e.addr || got.data !== e.data) begin
      n_errors++;
      $display("FAIL store_cdb_issue: ok=%0b got op=%0b tag=%h addr=%h data=%h, want op=%0b tag=%h addr=%h data=%h",
               ok, got.op, got.tag, got.addr, got.data, e.op, e.tag, e.addr, e.data);
    end
  endtask

  task automatic test_bypass();
    cdb_valid = 1'b1; cdb_tag = 6'h07; cdb_data = 32'h1234_5678;
    drive_disp(1'b1, 6'h08, 32'h0000_3000, 16'h8000, 32'h0, 1'b0, 6'h07, 32'h1234_5678);
    cdb_valid = 1'b0;
    take_head(2, ok, got);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got.op !== e.op || got.tag !== e.tag || got.addr !== e.addr || got.data !== e.data) begin
      n_errors++;
      $display("FAIL bypass_issue: ok=%0b got op=%0b tag=%h addr=%h data=%h, want op=%0b tag=%h addr=%h data=%h",
               ok, got.op, got.tag, got.addr, got.data, e.op, e.tag, e.addr, e.data);
    end
  endtask

  task automatic test_order();
    bit seen_rdy;
    drive_disp(1'b1, 6'h10, 32'h0000_0080, 16'h0008, 32'h0, 1'b0, 6'h2A, 32'hCAFE_F00D);
    drive_disp(1'b0, 6'h11, 32'h0000_0040, 16'h0004, 32'h0, 1'b1, 6'h00, 32'h0);
    seen_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ls_ready_out) seen_rdy = 1'b1;
      step();
    end
    n_checks++;
    if (seen_rdy) begin
      n_errors++;
      $display("FAIL order_blocked: got rdy=1 while head store pending, want 0");
    end
    cdb_valid = 1'b1; cdb_tag = 6'h2A; cdb_data = 32'hCAFE_F00D;
    step();
    cdb_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      take_head(4, ok, got);
      e = sb.pop_front();
      n_checks++;
      if (!ok || got.op !== e.op || got.tag !== e.tag || got.addr !== e.addr || (e.op && got.data !== e.data)) begin
        n_errors++;
        $display("FAIL order_issue%0d: ok=%0b got op=%0b tag=%h addr=%h data=%h, want op=%0b tag=%h addr=%h data=%h",
                 k, ok, got.op, got.tag, got.addr, got.data, e.op, e.tag, e.addr, e.data);
      end
    end
  endtask

  task automatic test_full();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_disp(1'b0, 6'(6'h30 + i), 32'(i * 256), 16'(i), 32'h0, 1'b1, 6'h0, 32'h0);
    end
    n_checks++;
    if (lsq_full !== 1'b1 || lsq_count !== 4'd8) begin
      n_errors++;
      $display("FAIL full_flag: got full=%0b cnt=%0d, want full=1 cnt=8", lsq_full, lsq_count);
    end
    disp_valid = 1'b1; disp_opcode = 1'b0; disp_tag = 6'h3F; disp_base = 32'hFFFF_0000;
    disp_offset = 16'h0; disp_data_valid = 1'b1;
    step();
    disp_valid = 1'b0;
    n_checks++;
    if (lsq_full !== 1'b1 || lsq_count !== 4'd8) begin
      n_errors++;
      $display("FAIL full_ignore: got full=%0b cnt=%0d, want full=1 cnt=8", lsq_full, lsq_count);
    end
    take_head(4, ok, got);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got.tag !== e.tag || got.addr !== e.addr || lsq_full !== 1'b0 || lsq_count !== 4'd7) begin
      n_errors++;
      $display("FAIL full_pop: ok=%0b got tag=%h addr=%h full=%0b cnt=%0d, want tag=%h addr=%h full=0 cnt=7",
               ok, got.tag, got.addr, lsq_full, lsq_count, e.tag, e.addr);
    end
    drive_disp(1'b0, 6'h3E, 32'h0000_5000, 16'hFFFF, 32'h0, 1'b1, 6'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      take_head(4, ok, got);
      e = sb.pop_front();
      n_checks++;
      if (!ok || got.op !== e.op || got.tag !== e.tag || got.addr !== e.addr) begin
        n_errors++;
        $display("FAIL wrap_drain%0d: ok=%0b got op=%0b tag=%h addr=%h, want op=%0b tag=%h addr=%h",
                 k, ok, got.op, got.tag, got.addr, e.op, e.tag, e.addr);
      end
    end
    n_checks++;
    if (lsq_count !== 4'd0 || lsq_full !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_empty: got cnt=%0d full=%0b, want cnt=0 full=0", lsq_count, lsq_full);
    end
  endtask

  task automatic test_flush_and_reset();
    for (int i = 0; i < 5; i++) begin
      drive_disp(1'b0, 6'(6'h20 + i), 32'h0000_7000, 16'(i * 4), 32'h0, 1'b1, 6'h0, 32'h0);
    end
    n_checks++;
    if (ls_ready_out !== 1'b1 || lsq_count !== 4'd5) begin
      n_errors++;
      $display("FAIL flush_pre: got rdy=%0b cnt=%0d, want rdy=1 cnt=5", ls_ready_out, lsq_count);
    end
    flush = 1'b1; ls_accept = 1'b1;
    step();
    flush = 1'b0; ls_accept = 1'b0;
    sb.delete();
    n_checks++;
    if (ls_ready_out !== 1'b0 || lsq_count !== 4'd0 || lsq_full !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_clear: got rdy=%0b cnt=%0d full=%0b, want 0 0 0", ls_ready_out, lsq_count, lsq_full);
    end
    step(); step();
    n_checks++;
    if (ls_ready_out !== 1'b0 || lsq_count !== 4'd0) begin
      n_errors++;
      $display("FAIL flush_stays_empty: got rdy=%0b cnt=%0d, want 0 0", ls_ready_out, lsq_count);
    end
    drive_disp(1'b0, 6'h2B, 32'h0000_9000, 16'h0020, 32'h0, 1'b1, 6'h0, 32'h0);
    take_head(4, ok, got);
    e = sb.pop_front();
    n_checks++;
    if (!ok || got.tag !== e.tag || got.addr !== e.addr || got.op !== e.op) begin
      n_errors++;
      $display("FAIL flush_reuse: ok=%0b got tag=%h addr=%h op=%0b, want tag=%h addr=%h op=%0b",
               ok, got.tag, got.addr, got.op, e.tag, e.addr, e.op);
    end
    drive_disp(1'b0, 6'h2C, 32'h0000_A000, 16'h0000, 32'h0, 1'b1, 6'h0, 32'h0);
    step();
    n_checks++;
    if (ls_ready_out !== 1'b1) begin
      n_errors++;
      $display("FAIL areset_pre: got rdy=%0b, want 1", ls_ready_out);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ls_ready_out !== 1'b0 || lsq_count !== 4'd0 || ls_address !== 32'h0 || ls_tag !== 6'h0) begin
      n_errors++;
      $display("FAIL areset_async: got rdy=%0b cnt=%0d addr=%h tag=%h, want all zero",
               ls_ready_out, lsq_count, ls_address, ls_tag);
    end
    sb.delete();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store_cdb();
    test_bypass();
    test_order();
    test_full();
    test_flush_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
